// File: rtl/br_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: FSM states, scan codes,
// held-key record, default timing constants and the parity helper.
package br_ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DECODE
    } ps2_state_t;

    // Prefix bytes and the game keys of interest
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam int FILTER_LEN_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 100000;

    // Held state of the game keys; up is the most significant bit
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic space;
        logic enter;
    } keys_t;

    // Odd parity: data ones plus the parity bit must be an odd count
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the PS/2 lines and the decoded key outputs.
// slave: the decoder (reads the PS/2 lines, drives the results).
// master: the keyboard side / consumer (drives the lines, reads the results).
interface ps2_key_decoder_if;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       key_space;
    logic       key_enter;

    modport master (
        output ps2c, ps2d,
        input  code, code_valid, is_break, is_extended, frame_err,
        input  key_up, key_down, key_left, key_right, key_space, key_enter
    );

    modport slave (
        input  ps2c, ps2d,
        output code, code_valid, is_break, is_extended, frame_err,
        output key_up, key_down, key_left, key_right, key_space, key_enter
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchroniser, glitch filter that only
// moves after FILTER_LEN agreeing samples, and a 1->0 strobe on the filtered
// level. Everything resets to the released (high) line level.
module ps2_line_filter
    import br_ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic line,
    output logic filt,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             filt_reg;
    logic             filt_next;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Bring the asynchronous line into the clk domain
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= line;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive samples that disagree with the filtered level
    always_comb begin
        filt_next = filt_reg;
        cnt_next  = '0;
        if (sync2_reg != filt_reg) begin
            if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
                filt_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // Filtered level, run length and the registered falling-edge strobe
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            filt_reg <= 1'b1;
            cnt_reg  <= '0;
            fall_reg <= 1'b0;
        end else begin
            filt_reg <= filt_next;
            cnt_reg  <= cnt_next;
            fall_reg <= filt_reg & ~filt_next;
        end
    end

    assign filt = filt_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, resolves the E0/F0
// prefixes and publishes scan-code events plus held flags for the game keys.
module ps2_key_decoder
    import br_ps2_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF   // must be at least 2
) (
    input  logic clk,
    input  logic clr,
    ps2_key_decoder_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic ps2c_filt_unused;
    logic ps2c_fall;
    logic ps2d_filt;
    logic ps2d_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .clr  (clr),
        .line (bus.ps2c),
        .filt (ps2c_filt_unused),
        .fall (ps2c_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .clr  (clr),
        .line (bus.ps2d),
        .filt (ps2d_filt),
        .fall (ps2d_fall_unused)
    );

    ps2_state_t       state_reg,      state_next;
    logic [2:0]       bit_cnt_reg,    bit_cnt_next;
    logic [7:0]       shift_reg,      shift_next;
    logic             par_reg,        par_next;
    logic             ext_pend_reg,   ext_pend_next;
    logic             brk_pend_reg,   brk_pend_next;
    logic [7:0]       code_reg,       code_next;
    logic             code_valid_reg, code_valid_next;
    logic             is_break_reg,   is_break_next;
    logic             is_ext_reg,     is_ext_next;
    logic             frame_err_reg,  frame_err_next;
    keys_t            keys_reg,       keys_next;
    logic [TMO_W-1:0] tmo_reg;
    logic             timeout;

    // Cycles elapsed since the last fall while a frame is in progress
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tmo_reg <= '0;
        end else if (ps2c_fall) begin
            tmo_reg <= TMO_W'(1);
        end else if (state_reg == ST_IDLE) begin
            tmo_reg <= '0;
        end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
        end
    end

    // The registered error lands exactly TIMEOUT_CYC cycles after the last fall
    assign timeout = (state_reg != ST_IDLE) && !ps2c_fall &&
                     (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));

    // Frame FSM next state, prefix tracking and event/flag generation
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        par_next        = par_reg;
        ext_pend_next   = ext_pend_reg;
        brk_pend_next   = brk_pend_reg;
        code_next       = code_reg;
        code_valid_next = 1'b0;
        is_break_next   = is_break_reg;
        is_ext_next     = is_ext_reg;
        frame_err_next  = 1'b0;
        keys_next       = keys_reg;

        if (timeout) begin
            frame_err_next = 1'b1;
            ext_pend_next  = 1'b0;
            brk_pend_next  = 1'b0;
            state_next     = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A fall with data high is line noise, not a start bit
                    if (ps2c_fall && !ps2d_filt) begin
                        bit_cnt_next = 3'd0;
                        state_next   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ps2c_fall) begin
                        shift_next = {ps2d_filt, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            state_next = ST_PARITY;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (ps2c_fall) begin
                        par_next   = ps2d_filt;
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (ps2c_fall) begin
                        if (ps2d_filt && odd_parity_ok(shift_reg, par_reg)) begin
                            state_next = ST_DECODE;
                        end else begin
                            frame_err_next = 1'b1;
                            ext_pend_next  = 1'b0;
                            brk_pend_next  = 1'b0;
                            state_next     = ST_IDLE;
                        end
                    end
                end
                ST_DECODE: begin
                    state_next = ST_IDLE;
                    if (shift_reg == SC_EXT) begin
                        ext_pend_next = 1'b1;
                    end else if (shift_reg == SC_BRK) begin
                        brk_pend_next = 1'b1;
                    end else begin
                        code_valid_next = 1'b1;
                        code_next       = shift_reg;
                        is_break_next   = brk_pend_reg;
                        is_ext_next     = ext_pend_reg;
                        ext_pend_next   = 1'b0;
                        brk_pend_next   = 1'b0;
                        // Arrow keys only match with E0, space/enter only without
                        if (ext_pend_reg) begin
                            case (shift_reg)
                                SC_UP:    keys_next.up    = !brk_pend_reg;
                                SC_DOWN:  keys_next.down  = !brk_pend_reg;
                                SC_LEFT:  keys_next.left  = !brk_pend_reg;
                                SC_RIGHT: keys_next.right = !brk_pend_reg;
                                default:  ;
                            endcase
                        end else begin
                            case (shift_reg)
                                SC_SPACE: keys_next.space = !brk_pend_reg;
                                SC_ENTER: keys_next.enter = !brk_pend_reg;
                                default:  ;
                            endcase
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state, frame datapath and registered outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            par_reg        <= 1'b0;
            ext_pend_reg   <= 1'b0;
            brk_pend_reg   <= 1'b0;
            code_reg       <= '0;
            code_valid_reg <= 1'b0;
            is_break_reg   <= 1'b0;
            is_ext_reg     <= 1'b0;
            frame_err_reg  <= 1'b0;
            keys_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            par_reg        <= par_next;
            ext_pend_reg   <= ext_pend_next;
            brk_pend_reg   <= brk_pend_next;
            code_reg       <= code_next;
            code_valid_reg <= code_valid_next;
            is_break_reg   <= is_break_next;
            is_ext_reg     <= is_ext_next;
            frame_err_reg  <= frame_err_next;
            keys_reg       <= keys_next;
        end
    end

    assign bus.code        = code_reg;
    assign bus.code_valid  = code_valid_reg;
    assign bus.is_break    = is_break_reg;
    assign bus.is_extended = is_ext_reg;
    assign bus.frame_err   = frame_err_reg;
    assign bus.key_up      = keys_reg.up;
    assign bus.key_down    = keys_reg.down;
    assign bus.key_left    = keys_reg.left;
    assign bus.key_right   = keys_reg.right;
    assign bus.key_space   = keys_reg.space;
    assign bus.key_enter   = keys_reg.enter;

endmodule
